// File: rtl/booth_wallace_multiplier.sv
// Signed 32x32 -> 64-bit multiplier: radix-4 Booth partial products, carry-save
// (Wallace) reduction to two rows, final carry-propagate add, optional output register.
module booth_wallace_multiplier #(
  parameter int unsigned PIPE_STAGES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] P
);

  localparam int unsigned AW    = 32;
  localparam int unsigned PW    = 64;
  localparam int unsigned NDIG  = AW / 2;
  localparam int unsigned NROWS = NDIG + 1;
  localparam int unsigned IW    = 5;
  localparam int unsigned BW    = 6;
  localparam int unsigned NLVL  = 6;
  localparam int unsigned MAXG  = NROWS / 3;

  logic [PW-1:0] pp_rows_c [NROWS];
  logic [PW-1:0] sum_c;
  logic [PW-1:0] carry_c;
  logic [PW-1:0] prod_c;

  // Booth digit select; negated rows are one's complement, the +1 lives in the last row
  always_comb begin : booth_pp
    logic [AW:0]   b_ext;
    logic [2:0]    trip;
    logic [AW+1:0] a_x1;
    logic [AW+1:0] a_x2;
    logic [AW+1:0] mag;
    logic [AW+1:0] pp;
    logic          neg;
    logic [PW-1:0] negbits;
    b_ext   = {B, 1'b0};
    a_x1    = {{2{A[AW-1]}}, A};
    a_x2    = {A[AW-1], A, 1'b0};
    negbits = '0;
    for (int i = 0; i < NDIG; i++) begin
      trip = b_ext[BW'(2*i) +: 3];
      mag  = '0;
      neg  = 1'b0;
      case (trip)
        3'b001, 3'b010: mag = a_x1;
        3'b011:         mag = a_x2;
        3'b100: begin mag = a_x2; neg = 1'b1; end
        3'b101, 3'b110: begin mag = a_x1; neg = 1'b1; end
        default:        mag = '0;
      endcase
      pp = neg ? ~mag : mag;
      pp_rows_c[IW'(i)] = {{(PW-AW-2){pp[AW+1]}}, pp} << (2*i);
      negbits[BW'(2*i)] = neg;
    end
    pp_rows_c[IW'(NDIG)] = negbits;
  end

  // Levels of 3:2 compressors: 17 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2 rows
  always_comb begin : wallace
    logic [PW-1:0] w  [NROWS];
    logic [PW-1:0] nx [NROWS];
    logic [IW-1:0] n;
    logic [IW-1:0] m;
    logic [IW-1:0] rem_base;
    w = pp_rows_c;
    n = IW'(NROWS);
    for (int lvl = 0; lvl < NLVL; lvl++) begin
      nx = '{default: '0};
      m  = '0;
      for (int g = 0; g < MAXG; g++) begin
        if (IW'(3*g+2) < n) begin
          nx[m]        = w[IW'(3*g)] ^ w[IW'(3*g+1)] ^ w[IW'(3*g+2)];
          nx[m + 1'b1] = ((w[IW'(3*g)] & w[IW'(3*g+1)]) |
                          (w[IW'(3*g)] & w[IW'(3*g+2)]) |
                          (w[IW'(3*g+1)] & w[IW'(3*g+2)])) << 1;
          m = m + IW'(2);
        end
      end
      rem_base = n - (n % IW'(3));
      for (int r = 0; r < NROWS; r++) begin
        if (IW'(r) >= rem_base && IW'(r) < n) begin
          nx[m] = w[IW'(r)];
          m = m + 1'b1;
        end
      end
      w = nx;
      n = m;
    end
    sum_c   = w[0];
    carry_c = w[1];
  end

  assign prod_c = sum_c + carry_c;

  if (PIPE_STAGES == 0) begin : g_comb
    logic unused_c;
    assign unused_c = ^{clk, rst};
    assign P = prod_c;
  end else begin : g_pipe
    logic [PW-1:0] p_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) p_q <= '0;
      else     p_q <= prod_c;
    end
    assign P = p_q;
  end

endmodule

// File: tb/tb_booth_wallace_multiplier.sv
// Directed bench for the combinational and single-register variants of the multiplier.
module tb_booth_wallace_multiplier;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] p_comb;
  logic [63:0] p_pipe;
  int          total;
  int          bad;

  booth_wallace_multiplier #(.PIPE_STAGES(0)) dut_comb (
    .clk(clk), .rst(rst), .A(a), .B(b), .P(p_comb)
  );

  booth_wallace_multiplier #(.PIPE_STAGES(1)) dut_pipe (
    .clk(clk), .rst(rst), .A(a), .B(b), .P(p_pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic comb_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic [63:0] exp);
    a = va;
    b = vb;
    #10;
    check(tag, p_comb, exp);
  endtask

  function automatic logic [63:0] golden(input logic [31:0] va, input logic [31:0] vb);
    longint sa;
    longint sb;
    sa = longint'($signed(va));
    sb = longint'($signed(vb));
    return 64'(sa * sb);
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [63:0] pe [4];
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a     = '0;
    b     = '0;
    #3;
    check("pipe_reset", p_pipe, 64'h0);

    comb_vec("zero",      32'd0,        32'd0,        64'd0);
    comb_vec("7x9",       32'd7,        32'd9,        64'd63);
    comb_vec("m15x4",     -32'sd15,     32'd4,        64'hFFFF_FFFF_FFFF_FFC4);
    comb_vec("m25xm13",   -32'sd25,     -32'sd13,     64'd325);
    comb_vec("maxx2",     32'h7FFF_FFFF, 32'd2,       64'h0000_0000_FFFF_FFFE);
    comb_vec("minx1",     32'h8000_0000, 32'd1,       64'hFFFF_FFFF_8000_0000);
    comb_vec("minxmin",   32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    comb_vec("m1xm1",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    comb_vec("minxm1",    32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    comb_vec("1xAAAA",    32'd1,        32'hAAAA_AAAA, 64'hFFFF_FFFF_AAAA_AAAA);
    comb_vec("m1x5555",   32'hFFFF_FFFF, 32'h5555_5555, 64'hFFFF_FFFF_AAAA_AAAB);
    comb_vec("3xFFFF",    32'd3,        32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD);
    comb_vec("boothAA",   32'h1234_5678, 32'hAAAA_AAAA, golden(32'h1234_5678, 32'hAAAA_AAAA));
    comb_vec("booth55",   32'hDEAD_BEEF, 32'h5555_5555, golden(32'hDEAD_BEEF, 32'h5555_5555));
    comb_vec("boothFF",   32'h7FFF_FFFF, 32'hFFFF_FFFF, golden(32'h7FFF_FFFF, 32'hFFFF_FFFF));

    for (int k = 0; k < 24; k++) begin
      ra = $urandom;
      rb = $urandom;
      comb_vec("random", ra, rb, golden(ra, rb));
    end

    check("pipe_held_in_reset", p_pipe, 64'h0);

    // Release reset and confirm one-cycle latency
    @(negedge clk);
    rst = 1'b0;
    a   = 32'd7;
    b   = 32'd9;
    #1;
    check("pipe_before_edge", p_pipe, 64'h0);
    @(posedge clk);
    #1;
    check("pipe_7x9", p_pipe, 64'd63);

    pa[0] = 32'd100;        pb[0] = -32'sd3;        pe[0] = 64'hFFFF_FFFF_FFFF_FED4;
    pa[1] = 32'h8000_0000;  pb[1] = 32'h8000_0000;  pe[1] = 64'h4000_0000_0000_0000;
    pa[2] = -32'sd25;       pb[2] = -32'sd13;       pe[2] = 64'd325;
    pa[3] = 32'h7FFF_FFFF;  pb[3] = 32'd2;          pe[3] = 64'h0000_0000_FFFF_FFFE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a = pa[k];
      b = pb[k];
      @(posedge clk);
      #1;
      check("pipe_b2b", p_pipe, pe[k]);
    end

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("pipe_async_rst", p_pipe, 64'h0);

    // In-flight product dropped by reset
    @(negedge clk);
    rst = 1'b0;
    a   = 32'd5;
    b   = 32'd6;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("pipe_inflight_drop", p_pipe, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("pipe_after_drop", p_pipe, 64'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
